// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: instruction-buffer geometry and entry layout.
package cpu_defs;

  localparam int unsigned IB_DEPTH   = 8;
  localparam int unsigned IB_PTR_W   = 3;
  localparam int unsigned IB_ENTRY_W = 65;

  // Layout {excp, pc, inst}: INST [31:0], PC [63:32], EXCP [64].
  typedef struct packed {
    logic        excp;
    logic [31:0] pc;
    logic [31:0] inst;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch-check and decode: in-order FIFO with
// count-based full/empty, flushed by redirect, exception or ertn.
module inst_buffer
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH,
  parameter int unsigned PTR_W = IB_PTR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic        ib_valid,
  output logic        ib_ready,
  input  logic [31:0] inst_i,
  input  logic [31:0] vaddr_i,
  input  logic        excp_i,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_excp
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  ib_entry_t        mem [DEPTH];
  ib_entry_t        wr_entry;
  ib_entry_t        head_entry;
  logic             any_flush;
  logic             push;
  logic             pop;

  assign any_flush = flush | excp_flush | ertn_flush;

  // Handshake status depends only on registered count.
  assign ib_ready = (count != CNT_W'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = ib_valid & ib_ready;
  assign pop      = id_valid & id_ready;

  assign wr_entry = '{excp: excp_i, pc: vaddr_i, inst: inst_i};

  // Pointers and occupancy; a flush cycle discards both push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (any_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; stale contents are hidden by the count mask.
  always_ff @(posedge clk) begin
    if (push && !any_flush) mem[tail] <= wr_entry;
  end

  always_comb begin
    head_entry = '0;
    if (id_valid) head_entry = mem[head];
  end

  assign id_inst = head_entry.inst;
  assign id_pc   = head_entry.pc;
  assign id_excp = head_entry.excp;

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer: stimulus queues expected entries,
// a negedge monitor checks the head presented to decode.
module tb_inst_buffer;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, excp_flush, ertn_flush;
  logic        ib_valid, ib_ready;
  logic [31:0] inst_i, vaddr_i;
  logic        excp_i;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;
  logic        id_excp;

  int checks = 0;
  int passed = 0;
  logic [64:0] sb [$];

  inst_buffer dut (
    .clk(clk), .reset(reset),
    .flush(flush), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .ib_valid(ib_valid), .ib_ready(ib_ready),
    .inst_i(inst_i), .vaddr_i(vaddr_i), .excp_i(excp_i),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst(id_inst), .id_pc(id_pc), .id_excp(id_excp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Monitor: compares the presented head against the scoreboard and retires pops.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("id_valid", 65'(id_valid), 65'(sb.size() != 0));
        if (sb.size() != 0) begin
          chk("head_entry", {id_excp, id_pc, id_inst}, sb[0]);
          if (id_ready && !(flush | excp_flush | ertn_flush)) void'(sb.pop_front());
        end else begin
          chk("empty_mask", {id_excp, id_pc, id_inst}, 65'd0);
        end
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic e, input logic rdy, input logic [2:0] fl);
    logic acc;
    ib_valid = v; vaddr_i = pc; inst_i = inst; excp_i = e; id_ready = rdy;
    {flush, excp_flush, ertn_flush} = fl;
    acc = v && (sb.size() != DEPTH);
    chk("ib_ready", 65'(ib_ready), 65'(sb.size() != DEPTH));
    @(posedge clk);
    if (fl != 3'b000) sb.delete();
    else if (acc) sb.push_back({e, pc, inst});
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, 1'b0, rdy, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
    ib_valid = 1'b0; inst_i = '0; vaddr_i = '0; excp_i = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_id_valid", 65'(id_valid), 65'd0);
    chk("rst_ib_ready", 65'(ib_ready), 65'd1);
    chk("rst_id_pc",    65'(id_pc),    65'd0);

    // Single push, held until decode accepts
    step(1'b1, 32'h1c000000, 32'h02800400, 1'b0, 1'b0, 3'b000);
    chk("single_pc", 65'(id_pc), 65'h1c000000);
    chk("single_inst", 65'(id_inst), 65'h02800400);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    chk("single_drained", 65'(id_valid), 65'd0);
    idle(1'b0);

    // Fill to capacity, then a refused push alongside a pop, then drain
    for (int k = 0; k < 8; k++)
      step(1'b1, 32'h1c000000 + 32'(4 * k), 32'h00100000 + 32'(k), 1'(k & 1), 1'b0, 3'b000);
    chk("full_ready", 65'(ib_ready), 65'd0);
    step(1'b1, 32'hdeadbeef, 32'hcafef00d, 1'b1, 1'b1, 3'b000);
    for (int k = 0; k < 8; k++) idle(1'b1);
    chk("fill_drained", 65'(id_valid), 65'd0);

    // Streaming through pointer wrap
    for (int k = 0; k < 20; k++)
      step(1'b1, 32'h1c001000 + 32'(4 * k), 32'h02a00000 + 32'(k), 1'(k % 3 == 0), 1'b1, 3'b000);
    idle(1'b1);
    idle(1'b0);

    // Exception flush with concurrent push and pop
    for (int k = 0; k < 5; k++)
      step(1'b1, 32'h1c002000 + 32'(4 * k), 32'h03400000 + 32'(k), 1'b0, 1'b0, 3'b000);
    step(1'b1, 32'h1c0020ff, 32'h0badf00d, 1'b0, 1'b1, 3'b010);
    chk("flush_valid", 65'(id_valid), 65'd0);
    chk("flush_ready", 65'(ib_ready), 65'd1);
    idle(1'b1);

    // Combined flush sources after refilling
    step(1'b1, 32'h1c003000, 32'h11111111, 1'b1, 1'b0, 3'b000);
    step(1'b1, 32'h1c003004, 32'h22222222, 1'b0, 1'b0, 3'b000);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b101);
    chk("multi_flush_valid", 65'(id_valid), 65'd0);
    step(1'b1, 32'h1c004000, 32'h33333333, 1'b0, 1'b0, 3'b000);
    idle(1'b1);

    // Asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h1c005000 + 32'(4 * k), 32'h44440000 + 32'(k), 1'b0, 1'b0, 3'b000);
    ib_valid = 1'b0;
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_valid", 65'(id_valid), 65'd0);
    chk("async_rst_ready", 65'(ib_ready), 65'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    idle(1'b1);
    chk("post_rst_pc", 65'(id_pc), 65'd0);
    step(1'b1, 32'h1c006000, 32'h55555555, 1'b1, 1'b0, 3'b000);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
